// File: rtl/req_srv_pkg.sv
// Shared definitions for the request pending server: default line count and
// the output-register state encoding.
package req_srv_pkg;

  localparam int REQ_N_DEFAULT = 4;

  typedef enum logic {
    SRV_IDLE    = 1'b0,
    SRV_PRESENT = 1'b1
  } srv_state_t;

endpackage

// File: rtl/lowest_set_finder.sv
// Combinational lowest-set-bit finder; idx is 0 when vec is all zero.
module lowest_set_finder #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_pending_server.sv
// Edge-captures request lines into pending bits and serves them one per
// handshake through a registered valid/ready output, lowest index first.
module req_pending_server
  import req_srv_pkg::*;
#(
  parameter int N     = REQ_N_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             clr_all,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_pos,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     overflow,
  output srv_state_t       dbg_state
);

  // Handshake: a position transfers on a rising edge where out_valid and
  // out_ready are both 1; out_valid/out_pos never depend on out_ready
  // combinationally, and out_pos is stable while out_valid=1 and out_ready=0.

  srv_state_t       state_q, state_d;
  logic [N-1:0]     req_q, req_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     overflow_q, overflow_d;
  logic [IDX_W-1:0] out_pos_q, out_pos_d;

  logic [N-1:0]     rise;
  logic [N-1:0]     load_clr;
  logic [IDX_W-1:0] low_idx;
  logic             low_any;
  logic             free;
  logic             load;

  lowest_set_finder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_finder (
    .vec (pending_q),
    .idx (low_idx),
    .any (low_any)
  );

  assign rise = req_in & ~req_q;
  assign free = (state_q == SRV_IDLE) || out_ready;
  assign load = free && low_any;

  always_comb begin
    load_clr = '0;
    if (load) load_clr[low_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SRV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (clr_all) begin
      state_d = SRV_IDLE;
    end else if (free) begin
      state_d = low_any ? SRV_PRESENT : SRV_IDLE;
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == SRV_PRESENT);
    dbg_state = state_q;
  end

  // Datapath next values. A rise coinciding with a load of the same bit
  // re-sets it: those are two distinct events, so no overflow.
  always_comb begin
    req_d      = req_in;
    pending_d  = (pending_q & ~load_clr) | rise;
    overflow_d = overflow_q | (rise & pending_q & ~load_clr);
    out_pos_d  = load ? low_idx : out_pos_q;
    if (clr_all) begin
      pending_d  = '0;
      overflow_d = '0;
      out_pos_d  = out_pos_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      out_pos_q  <= '0;
    end else begin
      req_q      <= req_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      out_pos_q  <= out_pos_d;
    end
  end

  assign out_pos  = out_pos_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_pending_server.sv
// Directed bench for req_pending_server: scoreboard of expected served
// positions plus point checks of pending/overflow/out_valid.
module tb_req_pending_server;
  import req_srv_pkg::*;

  localparam int N     = 4;
  localparam int IDX_W = $clog2(N);

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_in;
  logic             clr_all;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_pos;
  logic [N-1:0]     pending;
  logic [N-1:0]     overflow;
  srv_state_t       dbg_state;

  logic [IDX_W-1:0] exp_q[$];
  int checks;
  int passes;

  req_pending_server #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .clr_all   (clr_all),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .pending   (pending),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_state(input string name, input logic v, input logic [N-1:0] p,
                             input logic [N-1:0] o);
    check({name, ".out_valid"}, 32'(out_valid), 32'(v));
    check({name, ".pending"},   32'(pending),   32'(p));
    check({name, ".overflow"},  32'(overflow),  32'(o));
  endtask

  // Scoreboard monitor: an accept happens at the next rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL accept: unexpected out_pos %0d with empty expected queue", out_pos);
      end else begin
        logic [IDX_W-1:0] e;
        e = exp_q.pop_front();
        if (out_pos === e) passes++;
        else $display("FAIL accept: got out_pos %0d expected %0d", out_pos, e);
      end
    end
  end

  initial begin
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b0;
    req_in    = '0;
    clr_all   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_state("reset", 1'b0, 4'b0000, 4'b0000);
    check("reset.out_pos", 32'(out_pos), 32'd0);

    // Single event, ready held high
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    exp_q.push_back(2'd2);
    req_in = 4'b0100;
    tick();
    check_state("single.e0", 1'b0, 4'b0100, 4'b0000);
    tick();
    check_state("single.e1", 1'b1, 4'b0000, 4'b0000);
    check("single.e1.out_pos", 32'(out_pos), 32'd2);
    tick();
    check("single.e2.out_valid", 32'(out_valid), 32'd0);
    req_in = '0;
    tick();

    // Simultaneous events with backpressure
    out_ready = 1'b0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    req_in = 4'b1011;
    tick();
    check_state("multi.e0", 1'b0, 4'b1011, 4'b0000);
    tick();
    check_state("multi.e1", 1'b1, 4'b1010, 4'b0000);
    check("multi.e1.out_pos", 32'(out_pos), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("multi.stall.out_pos", 32'(out_pos), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("multi.acc1.out_pos", 32'(out_pos), 32'd1);
    tick();
    check("multi.acc2.out_pos", 32'(out_pos), 32'd3);
    check("multi.acc2.pending", 32'(pending), 32'd0);
    tick();
    check("multi.drain.out_valid", 32'(out_valid), 32'd0);
    req_in = '0;
    tick();

    // Overflow on line 1 while stalled
    out_ready = 1'b0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    req_in = 4'b0011;
    tick();
    tick();
    check_state("ovf.present", 1'b1, 4'b0010, 4'b0000);
    req_in = 4'b0001;
    tick();
    req_in = 4'b0011;
    tick();
    check_state("ovf.set", 1'b1, 4'b0010, 4'b0010);
    check("ovf.set.out_pos", 32'(out_pos), 32'd0);
    out_ready = 1'b1;
    tick();
    check("ovf.acc.out_pos", 32'(out_pos), 32'd1);
    tick();
    check_state("ovf.drain", 1'b0, 4'b0000, 4'b0010);
    req_in  = '0;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check("ovf.flush.overflow", 32'(overflow), 32'd0);

    // Set-wins race on line 0 at the edge it loads
    out_ready = 1'b0;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    req_in = 4'b0010;
    tick();
    tick();
    req_in = 4'b0011;
    tick();
    check_state("race.pend0", 1'b1, 4'b0001, 4'b0000);
    req_in = 4'b0010;
    tick();
    req_in    = 4'b0011;
    out_ready = 1'b1;
    tick();
    check_state("race.edge", 1'b1, 4'b0001, 4'b0000);
    check("race.edge.out_pos", 32'(out_pos), 32'd0);
    tick();
    check_state("race.second", 1'b1, 4'b0000, 4'b0000);
    check("race.second.out_pos", 32'(out_pos), 32'd0);
    tick();
    check("race.drain.out_valid", 32'(out_valid), 32'd0);
    req_in = '0;
    tick();

    // Flush mid-operation; held lines must not re-trigger
    out_ready = 1'b0;
    req_in    = 4'b1111;
    tick();
    tick();
    check_state("flush.pre", 1'b1, 4'b1110, 4'b0000);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check_state("flush.post", 1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    check_state("flush.held", 1'b0, 4'b0000, 4'b0000);

    // Reset mid-stream; held lines produce one event each after release
    req_in = 4'b0000;
    tick();
    req_in = 4'b0101;
    tick();
    tick();
    check_state("rst.pre", 1'b1, 4'b0100, 4'b0000);
    rst_n = 1'b0;
    tick();
    check_state("rst.in", 1'b0, 4'b0000, 4'b0000);
    check("rst.in.out_pos", 32'(out_pos), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    tick();
    check_state("rst.e0", 1'b0, 4'b0101, 4'b0000);
    tick();
    check("rst.e1.out_pos", 32'(out_pos), 32'd0);
    tick();
    check("rst.e2.out_pos", 32'(out_pos), 32'd2);
    tick();
    check_state("rst.drain", 1'b0, 4'b0000, 4'b0000);
    tick();

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
